// File: rtl/adc_channel_arbiter.sv
// Round-robin arbiter that shares one MCP3008 ADC controller between NUM_REQ
// requesters. One conversion is outstanding at a time; a conversion that
// gets no result within TIMEOUT_CYCLES WAIT cycles is answered with rsp_err.
//
// state   | meaning
// IDLE    | no conversion; pick the next requester round-robin from ptr
// ISSUE   | handshake with the granted requester and pulse adc_start
// WAIT    | conversion in flight; wait for adc_axiiv or the timeout
// RESPOND | one-cycle rsp_valid to the granted requester
module adc_channel_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_channel,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 adc_start,
  output logic [2:0]           adc_channel,
  input  logic                 adc_axiiv,
  input  logic [9:0]           adc_axiid,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [9:0]           rsp_data,
  output logic                 rsp_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   g_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         chan_q;
  logic [9:0]         data_q;
  logic               err_q;

  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  int                 idx;
  logic               issue_go;
  logic [2:0]         g_chan;
  logic               timeout_hit;
  logic [IDX_W-1:0]   ptr_next;

  // First asserted requester searching upward from ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // The handshake is decided in the ISSUE cycle itself so a withdrawn
  // request never sees req_ready or adc_start.
  assign issue_go    = (state_q == ISSUE) && req_valid[g_q];
  assign g_chan      = req_channel[3*int'(g_q) +: 3];
  // Count holds the number of completed WAIT cycles; the last WAIT cycle
  // is the one where it is about to reach TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ptr_next    = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

  // Arbitration FSM, grant/pointer bookkeeping, timeout counter and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      chan_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            g_q     <= grant_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_valid[g_q]) begin
            chan_q  <= g_chan;
            ptr_q   <= ptr_next;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (adc_axiiv) begin
            data_q  <= adc_axiid;
            err_q   <= 1'b0;
            state_q <= RESPOND;
          end else if (timeout_hit) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            state_q <= RESPOND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESPOND: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = issue_go ? (NUM_REQ'(1) << g_q) : '0;
  assign adc_start   = issue_go;
  assign adc_channel = issue_go ? g_chan : chan_q;
  assign rsp_valid   = (state_q == RESPOND) ? (NUM_REQ'(1) << g_q) : '0;
  assign rsp_data    = data_q;
  assign rsp_err     = (state_q == RESPOND) && err_q;

endmodule

// File: tb/tb_adc_channel_arbiter.sv
// Self-checking bench for adc_channel_arbiter: directed scenarios plus random
// transactions predicted by a transaction-level round-robin model.
module tb_adc_channel_arbiter;

  localparam int NR = 4;
  localparam int TO = 1023;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [3*NR-1:0] req_channel;
  logic [NR-1:0]   req_ready;
  logic            adc_start;
  logic [2:0]      adc_channel;
  logic            adc_axiiv;
  logic [9:0]      adc_axiid;
  logic [NR-1:0]   rsp_valid;
  logic [9:0]      rsp_data;
  logic            rsp_err;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;

  adc_channel_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_channel(req_channel), .req_ready(req_ready),
    .adc_start(adc_start), .adc_channel(adc_channel),
    .adc_axiiv(adc_axiiv), .adc_axiid(adc_axiid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference round-robin: first valid requester at or after ptr, with wrap.
  function automatic int model_grant(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // One complete transaction; result arrives in WAIT cycle delay+1.
  task automatic run_txn(input logic [NR-1:0] valid, input logic [3*NR-1:0] chans,
                         input int delay, input logic [9:0] data, output int granted);
    int g;
    logic [2:0] ech;
    logic [NR-1:0] eoh;
    g = model_grant(valid, m_ptr);
    ech = chans[3*g +: 3];
    eoh = NR'(1) << g;
    req_valid = valid; req_channel = chans; #1;
    n_checks++;
    if (req_ready !== '0 || adc_start !== 1'b0) begin
      n_errors++; $display("FAIL idle_outputs: ready=%b start=%b required 0/0", req_ready, adc_start);
    end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== eoh || adc_start !== 1'b1 || adc_channel !== ech) begin
      n_errors++;
      $display("FAIL issue: ready=%b start=%b ch=%0d required %b/1/%0d", req_ready, adc_start, adc_channel, eoh, ech);
    end
    m_ptr = (g + 1) % NR;
    @(posedge clk); #1;
    req_valid = '0; req_channel = 12'($urandom);
    for (int d = 0; d < delay; d++) begin
      #1;
      n_checks++;
      if (adc_start !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || adc_channel !== ech) begin
        n_errors++;
        $display("FAIL wait_quiet: start=%b rsp=%b ready=%b ch=%0d required 0/0/0/%0d", adc_start, rsp_valid, req_ready, adc_channel, ech);
      end
      @(posedge clk); #1;
    end
    adc_axiiv = 1'b1; adc_axiid = data; #1;
    n_checks++;
    if (rsp_valid !== '0) begin
      n_errors++; $display("FAIL rsp_early: rsp=%b required 0", rsp_valid);
    end
    @(posedge clk); #1;
    adc_axiiv = 1'b0; adc_axiid = 10'($urandom);
    n_checks++;
    if (rsp_valid !== eoh || rsp_data !== data || rsp_err !== 1'b0 || adc_channel !== ech) begin
      n_errors++;
      $display("FAIL respond: rsp=%b data=%h err=%b ch=%0d required %b/%h/0/%0d", rsp_valid, rsp_data, rsp_err, adc_channel, eoh, data, ech);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== '0) begin
      n_errors++; $display("FAIL rsp_one_cycle: rsp=%b required 0", rsp_valid);
    end
    granted = g;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '1; req_channel = 12'hFFF; adc_axiiv = 1'b1; adc_axiid = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== '0 || adc_start !== 1'b0 || adc_channel !== 3'd0 || rsp_valid !== '0 ||
        rsp_data !== 10'd0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: ready=%b start=%b ch=%0d rsp=%b data=%h err=%b required all 0",
               req_ready, adc_start, adc_channel, rsp_valid, rsp_data, rsp_err);
    end
    req_valid = '0; adc_axiiv = 1'b0; adc_axiid = '0; req_channel = '0;
    rst = 1'b1; m_ptr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    int g;
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 12'o7531, i, 10'(i * 37 + 5), g);
      n_checks++;
      if (g !== exp_g[i]) begin
        n_errors++; $display("FAIL rr_order[%0d]: grant=%0d required %0d", i, g, exp_g[i]);
      end
    end
  endtask

  task automatic test_single();
    int g;
    run_txn(4'b0100, 12'o0500, 0, 10'h2A7, g);
    n_checks++;
    if (g !== 2) begin
      n_errors++; $display("FAIL single_grant: grant=%0d required 2", g);
    end
  endtask

  task automatic test_skip();
    int g;
    run_txn(4'b0010, 12'o1234, 2, 10'h155, g);
    n_checks++;
    if (m_ptr !== 2) begin
      n_errors++; $display("FAIL skip_setup: model ptr=%0d required 2", m_ptr);
    end
    run_txn(4'b0011, 12'o6543, 1, 10'h0AA, g);
    n_checks++;
    if (g !== 0) begin
      n_errors++; $display("FAIL skip_grant: grant=%0d required 0", g);
    end
  endtask

  task automatic test_random();
    int g;
    logic [NR-1:0] v;
    for (int i = 0; i < 25; i++) begin
      v = NR'($urandom_range(1, (1 << NR) - 1));
      run_txn(v, 12'($urandom), int'($urandom_range(0, 6)), 10'($urandom), g);
    end
  endtask

  task automatic test_timeout();
    int n;
    int g;
    logic [NR-1:0] eoh;
    g = model_grant(4'b1000, m_ptr);
    eoh = NR'(1) << g;
    req_valid = 4'b1000; req_channel = 12'o3000;
    @(posedge clk); #1;
    m_ptr = (g + 1) % NR;
    @(posedge clk); #1;
    req_valid = '0;
    n = 1;
    while (rsp_valid === '0 && n <= TO + 50) begin
      adc_axiid = 10'($urandom);
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== TO + 1) begin
      n_errors++; $display("FAIL timeout_latency: rsp after %0d wait cycles, required %0d", n - 1, TO);
    end
    n_checks++;
    if (rsp_valid !== eoh || rsp_err !== 1'b1 || rsp_data !== 10'd0) begin
      n_errors++; $display("FAIL timeout_rsp: rsp=%b err=%b data=%h required %b/1/000", rsp_valid, rsp_err, rsp_data, eoh);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== '0 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL timeout_clear: rsp=%b err=%b required 0/0", rsp_valid, rsp_err);
    end
    // Result on the last permitted WAIT cycle must beat the timeout.
    run_txn(4'b0001, 12'o0006, TO - 1, 10'h1C3, g);
  endtask

  task automatic test_withdraw();
    int old_ptr;
    int g;
    old_ptr = m_ptr;
    req_valid = 4'b0010; req_channel = 12'o0070;
    @(posedge clk); #1;
    req_valid = '0; #1;
    n_checks++;
    if (req_ready !== '0 || adc_start !== 1'b0) begin
      n_errors++; $display("FAIL withdraw_issue: ready=%b start=%b required 0/0", req_ready, adc_start);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== '0 || adc_start !== 1'b0 || rsp_valid !== '0) begin
        n_errors++; $display("FAIL withdraw_idle: ready=%b start=%b rsp=%b required 0", req_ready, adc_start, rsp_valid);
      end
    end
    run_txn(4'b1111, 12'o4321, 0, 10'h099, g);
    n_checks++;
    if (g !== old_ptr) begin
      n_errors++; $display("FAIL withdraw_ptr: grant=%0d required %0d", g, old_ptr);
    end
  endtask

  task automatic test_reset_in_wait();
    int g;
    req_valid = 4'b0100; req_channel = 12'o0700;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #2;
    rst = 1'b0; #1;
    n_checks++;
    if (req_ready !== '0 || adc_start !== 1'b0 || adc_channel !== 3'd0 || rsp_valid !== '0 ||
        rsp_data !== 10'd0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_wait_outputs: ready=%b start=%b ch=%0d rsp=%b data=%h err=%b required all 0",
               req_ready, adc_start, adc_channel, rsp_valid, rsp_data, rsp_err);
    end
    @(posedge clk); #1;
    rst = 1'b1; m_ptr = 0;
    adc_axiiv = 1'b1; adc_axiid = 10'h3C3;
    @(posedge clk); #1;
    adc_axiiv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rsp_valid !== '0 || adc_start !== 1'b0) begin
        n_errors++; $display("FAIL stray_axiiv: rsp=%b start=%b required 0/0", rsp_valid, adc_start);
      end
      @(posedge clk); #1;
    end
    run_txn(4'b1111, 12'o1111, 1, 10'h123, g);
    n_checks++;
    if (g !== 0) begin
      n_errors++; $display("FAIL post_reset_grant: grant=%0d required 0", g);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_channel = '0; adc_axiiv = 1'b0; adc_axiid = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_skip();
    test_random();
    test_timeout();
    test_withdraw();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_channel_arbiter.md
ADC_CHANNEL_ARBITER -- requirements
Module: adc_channel_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, the maximum WAIT duration before an error response.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester conversion request.
REQ-006 The block SHALL have port req_channel  input  3*NUM_REQ  MCP3008 channel per requester; requester i owns bits [3i+2:3i].
REQ-007 The block SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse; a request is taken when req_valid[i] and req_ready[i] are both high.
REQ-008 The block SHALL have port adc_start  output  1  one-cycle conversion start to the ADC controller.
REQ-009 The block SHALL have port adc_channel  output  3  channel for the started conversion; stable from adc_start until the response.
REQ-010 The block SHALL have port adc_axiiv  input  1  ADC result valid.
REQ-011 The block SHALL have port adc_axiid  input  10  ADC result data.
REQ-012 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle response to the granted requester.
REQ-013 The block SHALL have port rsp_data  output  10  result; valid only while any rsp_valid bit is high.
REQ-014 The block SHALL have port rsp_err  output  1  high with rsp_valid when the conversion timed out.

Function
REQ-015 The block SHALL implement the states IDLE, ISSUE, WAIT, RESPOND.
REQ-016 In IDLE with any req_valid high, the block SHALL register grant index g, the first asserted requester searching upward from priority pointer ptr with wrap, and SHALL move to ISSUE.
REQ-017 In IDLE with no req_valid high, the block SHALL remain in IDLE with all outputs deasserted.
REQ-018 In ISSUE, if req_valid[g] is still high, the block SHALL, in that same cycle, pulse req_ready[g] and adc_start, drive adc_channel from req_channel of g, set ptr to (g+1) mod NUM_REQ, clear the timeout counter, and move to WAIT.
REQ-019 In ISSUE, if req_valid[g] has dropped, the block SHALL return to IDLE with no handshake, no adc_start, and ptr unchanged.
REQ-020 In WAIT, on adc_axiiv high, the block SHALL capture adc_axiid into rsp_data, clear rsp_err, and move to RESPOND.
REQ-021 In WAIT, the timeout counter SHALL increment every cycle; when it reaches TIMEOUT_CYCLES without adc_axiiv, the block SHALL set rsp_data to 0 and rsp_err to 1, and move to RESPOND.
REQ-022 If adc_axiiv arrives in the same cycle that the count reaches TIMEOUT_CYCLES, the data SHALL win and rsp_err SHALL be 0.
REQ-023 In RESPOND, the block SHALL assert rsp_valid[g] for exactly one cycle and then return to IDLE.
REQ-024 adc_axiiv outside WAIT SHALL be ignored.
REQ-025 Latency SHALL be as follows: request seen in IDLE at cycle 0, req_ready and adc_start at cycle 1, rsp_valid one cycle after adc_axiiv.
REQ-026 At most one conversion SHALL be outstanding.
REQ-027 req_ready and rsp_valid SHALL each never have more than one bit set.
REQ-028 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL not wrap.

Reset
REQ-029 While rst is low, the block SHALL force state to IDLE, ptr to 0, g to 0, the counter to 0, req_ready, adc_start, rsp_valid and rsp_err to 0, rsp_data to 0, and adc_channel to 0.
REQ-030 Reset asserted mid-conversion SHALL abandon the conversion without a response; the first request after reset SHALL be arbitrated from ptr=0.
REQ-031 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-032 Single request: req_valid=4'b0100 with ch5 -> req_ready=4'b0100 and adc_start with adc_channel=5 one cycle later; adc_axiiv with 10'h2A7 -> rsp_valid=4'b0100, rsp_data=10'h2A7, rsp_err=0 on the next cycle.
REQ-033 Round-robin: all four requesters held valid -> grants in order 0,1,2,3,0.
REQ-034 Round-robin skip: with ptr=2 and only requesters 0 and 1 valid -> requester 0 is granted.
REQ-035 Timeout: no adc_axiiv for 1023 WAIT cycles -> rsp_valid with rsp_err=1 and rsp_data=0; with adc_axiiv on cycle 1023 -> rsp_err=0.
REQ-036 Withdrawn request: req_valid[1] drops during ISSUE -> no req_ready, no adc_start, return to IDLE, and the next grant still starts from the old ptr.
REQ-037 Reset in WAIT: rst low -> all outputs 0 immediately; a stray adc_axiiv after release -> no rsp_valid.
